// File: rtl/axi_aw_w_error_absorber_if.sv
// Bus bundle for the AW/W error absorber: upstream slave AW/W, downstream target AW/W,
// and the side channels to the write-response allocator.
interface axi_aw_w_error_absorber_if #(
    parameter int AXI_ID_IN  = 16,
    parameter int AXI_USER_W = 6,
    parameter int AXI_DATA_W = 64
) ();
    logic [AXI_ID_IN-1:0]    awid_i;
    logic [AXI_USER_W-1:0]   awuser_i;
    logic [7:0]              awlen_i;
    logic                    awvalid_i;
    logic                    awready_o;
    logic                    aw_decerr_i;
    logic                    awvalid_o;
    logic                    awready_i;
    logic [AXI_DATA_W-1:0]   wdata_i;
    logic [AXI_DATA_W/8-1:0] wstrb_i;
    logic                    wlast_i;
    logic [AXI_USER_W-1:0]   wuser_i;
    logic                    wvalid_i;
    logic                    wready_o;
    logic [AXI_DATA_W-1:0]   wdata_o;
    logic [AXI_DATA_W/8-1:0] wstrb_o;
    logic                    wlast_o;
    logic [AXI_USER_W-1:0]   wuser_o;
    logic                    wvalid_o;
    logic                    wready_i;
    logic                    full_counter_i;
    logic                    incr_req_o;
    logic                    sample_awdata_info_o;
    logic [AXI_ID_IN-1:0]    error_id_o;
    logic [AXI_USER_W-1:0]   error_user_o;
    logic                    error_req_o;
    logic                    error_gnt_i;
    logic                    wlast_mismatch_o;

    modport slave (
        input  awid_i, awuser_i, awlen_i, awvalid_i, aw_decerr_i, awready_i,
        input  wdata_i, wstrb_i, wlast_i, wuser_i, wvalid_i, wready_i,
        input  full_counter_i, error_gnt_i,
        output awready_o, awvalid_o, wready_o,
        output wdata_o, wstrb_o, wlast_o, wuser_o, wvalid_o,
        output incr_req_o, sample_awdata_info_o, error_id_o, error_user_o,
        output error_req_o, wlast_mismatch_o
    );

    modport master (
        output awid_i, awuser_i, awlen_i, awvalid_i, aw_decerr_i, awready_i,
        output wdata_i, wstrb_i, wlast_i, wuser_i, wvalid_i, wready_i,
        output full_counter_i, error_gnt_i,
        input  awready_o, awvalid_o, wready_o,
        input  wdata_o, wstrb_o, wlast_o, wuser_o, wvalid_o,
        input  incr_req_o, sample_awdata_info_o, error_id_o, error_user_o,
        input  error_req_o, wlast_mismatch_o
    );
endinterface

// File: rtl/axi_aw_w_error_absorber.sv
// AW/W front stage: forwards decoded writes to the target, absorbs decode-error writes
// (sinks their W burst) and then requests a DECERR response from the B allocator.
module axi_aw_w_error_absorber (
    input logic                      clk,
    input logic                      rst,
    axi_aw_w_error_absorber_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FWD_W   = 2'd1,
        SINK_W  = 2'd2,
        ERR_REQ = 2'd3
    } state_e;

    state_e     state_r;
    state_e     state_nxt_s;
    logic [7:0] beat_cnt_r;
    logic [7:0] beat_cnt_nxt_s;
    logic       mismatch_r;
    logic       mismatch_set_s;
    logic       beat_bad_s;

    // A beat disagrees with the burst length when WLAST and "no beats left" differ
    always_comb begin
        beat_bad_s = (bus.wlast_i && (beat_cnt_r != 8'd0)) ||
                     (!bus.wlast_i && (beat_cnt_r == 8'd0));
    end

    // State, remaining-beat counter and sticky mismatch flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            beat_cnt_r <= 8'd0;
            mismatch_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
            mismatch_r <= mismatch_r | mismatch_set_s;
        end
    end

    // Next-state decode and all handshake outputs
    always_comb begin
        state_nxt_s              = state_r;
        beat_cnt_nxt_s           = beat_cnt_r;
        mismatch_set_s           = 1'b0;
        bus.awready_o            = 1'b0;
        bus.awvalid_o            = 1'b0;
        bus.wready_o             = 1'b0;
        bus.wvalid_o             = 1'b0;
        bus.wdata_o              = '0;
        bus.wstrb_o              = '0;
        bus.wlast_o              = 1'b0;
        bus.wuser_o              = '0;
        bus.incr_req_o           = 1'b0;
        bus.sample_awdata_info_o = 1'b0;
        bus.error_req_o          = 1'b0;
        bus.error_id_o           = bus.awid_i;
        bus.error_user_o         = bus.awuser_i;

        case (state_r)
            IDLE: begin
                if (bus.awvalid_i && !bus.aw_decerr_i) begin
                    // Saturated allocator blocks legal writes only
                    bus.awvalid_o = !bus.full_counter_i;
                    bus.awready_o = bus.awready_i && !bus.full_counter_i;
                    if (bus.awready_i && !bus.full_counter_i) begin
                        bus.incr_req_o = 1'b1;
                        beat_cnt_nxt_s = bus.awlen_i;
                        state_nxt_s    = FWD_W;
                    end else begin
                        state_nxt_s    = IDLE;
                    end
                end else if (bus.awvalid_i && bus.aw_decerr_i) begin
                    bus.awready_o            = 1'b1;
                    bus.sample_awdata_info_o = 1'b1;
                    beat_cnt_nxt_s           = bus.awlen_i;
                    state_nxt_s              = SINK_W;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            FWD_W: begin
                bus.wvalid_o = bus.wvalid_i;
                bus.wready_o = bus.wready_i;
                bus.wdata_o  = bus.wdata_i;
                bus.wstrb_o  = bus.wstrb_i;
                bus.wlast_o  = bus.wlast_i;
                bus.wuser_o  = bus.wuser_i;
                if (bus.wvalid_i && bus.wready_i) begin
                    mismatch_set_s = beat_bad_s;
                    beat_cnt_nxt_s = beat_cnt_r - 8'd1;
                    if (bus.wlast_i) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = FWD_W;
                    end
                end else begin
                    state_nxt_s = FWD_W;
                end
            end

            SINK_W: begin
                bus.wready_o = 1'b1;
                if (bus.wvalid_i) begin
                    mismatch_set_s = beat_bad_s;
                    beat_cnt_nxt_s = beat_cnt_r - 8'd1;
                    if (bus.wlast_i) begin
                        state_nxt_s = ERR_REQ;
                    end else begin
                        state_nxt_s = SINK_W;
                    end
                end else begin
                    state_nxt_s = SINK_W;
                end
            end

            ERR_REQ: begin
                // Grant may be withheld for as long as legal writes are outstanding
                bus.error_req_o = 1'b1;
                if (bus.error_gnt_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ERR_REQ;
                end
            end

            default: begin
                state_nxt_s    = IDLE;
                beat_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    assign bus.wlast_mismatch_o = mismatch_r;

endmodule

// File: tb/tb_axi_aw_w_error_absorber.sv
// Directed bench for axi_aw_w_error_absorber; forwarded W beats are checked against a queue
// of the beats driven while a legal burst is in flight.
module tb_axi_aw_w_error_absorber;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   beats_seen;
    logic [78:0] exp_q[$];

    axi_aw_w_error_absorber_if #(.AXI_ID_IN(16), .AXI_USER_W(6), .AXI_DATA_W(64)) bus ();

    axi_aw_w_error_absorber dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every forwarded beat must match the oldest driven beat
    always @(negedge clk) begin
        if (!rst && bus.wvalid_o && bus.wready_i) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_fwd_beat", 96'd1, 96'd0);
            end else begin
                chk("fwd_beat", {bus.wdata_o, bus.wstrb_o, bus.wlast_o, bus.wuser_o},
                    exp_q.pop_front());
            end
        end
    end

    task automatic drive_beat(input logic last);
        bus.wdata_i  = {$urandom(), $urandom()};
        bus.wstrb_i  = 8'($urandom_range(0, 255));
        bus.wuser_i  = 6'($urandom_range(0, 63));
        bus.wlast_i  = last;
        bus.wvalid_i = 1'b1;
    endtask

    task automatic fwd_beat(input logic last);
        drive_beat(last);
        exp_q.push_back({bus.wdata_i, bus.wstrb_i, bus.wlast_i, bus.wuser_i});
        #1;
        chk("fwd_wready", 96'(bus.wready_o), 96'd1);
        tick();
        bus.wvalid_i = 1'b0;
    endtask

    task automatic sink_beat(input logic last);
        drive_beat(last);
        #1;
        chk("sink_wready", 96'(bus.wready_o), 96'd1);
        chk("sink_wvalid_o", 96'(bus.wvalid_o), 96'd0);
        tick();
        bus.wvalid_i = 1'b0;
    endtask

    task automatic set_aw(input logic [15:0] id, input logic [5:0] user, input logic [7:0] len,
                          input logic decerr);
        bus.awid_i      = id;
        bus.awuser_i    = user;
        bus.awlen_i     = len;
        bus.aw_decerr_i = decerr;
        bus.awvalid_i   = 1'b1;
    endtask

    initial begin
        tests = 0; fails = 0; beats_seen = 0;
        rst = 1'b1;
        bus.awid_i = '0; bus.awuser_i = '0; bus.awlen_i = 8'd0; bus.awvalid_i = 1'b0;
        bus.aw_decerr_i = 1'b0; bus.awready_i = 1'b1;
        bus.wdata_i = '0; bus.wstrb_i = '0; bus.wlast_i = 1'b0; bus.wuser_i = '0;
        bus.wvalid_i = 1'b0; bus.wready_i = 1'b1;
        bus.full_counter_i = 1'b0; bus.error_gnt_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_awready", 96'(bus.awready_o), 96'd0);
        chk("rst_wready", 96'(bus.wready_o), 96'd0);
        chk("rst_error_req", 96'(bus.error_req_o), 96'd0);
        chk("rst_mismatch", 96'(bus.wlast_mismatch_o), 96'd0);

        // Legal write, awlen=3
        tick();
        set_aw(16'h0001, 6'h01, 8'd3, 1'b0);
        #1;
        chk("legal_awvalid_o", 96'(bus.awvalid_o), 96'd1);
        chk("legal_awready_o", 96'(bus.awready_o), 96'd1);
        chk("legal_incr", 96'(bus.incr_req_o), 96'd1);
        chk("legal_no_sample", 96'(bus.sample_awdata_info_o), 96'd0);
        tick();
        bus.awvalid_i = 1'b0;
        for (int i = 0; i < 4; i++) fwd_beat(i == 3);
        #1;
        chk("legal_beats", 96'(beats_seen), 96'd4);
        bus.wvalid_i = 1'b1;
        #1;
        chk("legal_idle_wready", 96'(bus.wready_o), 96'd0);
        bus.wvalid_i = 1'b0;
        chk("legal_mismatch", 96'(bus.wlast_mismatch_o), 96'd0);

        // Error write, id 0x00A5 user 0x15 awlen=7
        tick();
        bus.awready_i = 1'b0;
        set_aw(16'h00A5, 6'h15, 8'd7, 1'b1);
        #1;
        chk("err_awready_o", 96'(bus.awready_o), 96'd1);
        chk("err_awvalid_o", 96'(bus.awvalid_o), 96'd0);
        chk("err_sample", 96'(bus.sample_awdata_info_o), 96'd1);
        chk("err_id", 96'(bus.error_id_o), 96'h00A5);
        chk("err_user", 96'(bus.error_user_o), 96'h15);
        chk("err_no_incr", 96'(bus.incr_req_o), 96'd0);
        tick();
        bus.awvalid_i = 1'b0; bus.aw_decerr_i = 1'b0; bus.awready_i = 1'b1;
        for (int i = 0; i < 8; i++) sink_beat(i == 7);
        for (int i = 0; i < 3; i++) begin
            chk("err_req_wait", 96'(bus.error_req_o), 96'd1);
            tick();
        end
        bus.error_gnt_i = 1'b1;
        #1;
        chk("err_req_at_gnt", 96'(bus.error_req_o), 96'd1);
        tick();
        bus.error_gnt_i = 1'b0;
        #1;
        chk("err_req_after_gnt", 96'(bus.error_req_o), 96'd0);
        chk("err_mismatch", 96'(bus.wlast_mismatch_o), 96'd0);

        // Two legal writes outstanding, then an error write held for 20 cycles
        for (int k = 0; k < 2; k++) begin
            set_aw(16'(k), 6'h02, 8'd0, 1'b0);
            #1;
            chk("out_incr", 96'(bus.incr_req_o), 96'd1);
            tick();
            bus.awvalid_i = 1'b0;
            fwd_beat(1'b1);
        end
        set_aw(16'h0BEE, 6'h2A, 8'd0, 1'b1);
        tick();
        bus.awvalid_i = 1'b0;
        sink_beat(1'b1);
        set_aw(16'h0003, 6'h03, 8'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("hold_error_req", 96'(bus.error_req_o), 96'd1);
            chk("hold_awready", 96'(bus.awready_o), 96'd0);
            tick();
        end
        bus.awvalid_i = 1'b0;
        bus.error_gnt_i = 1'b1;
        tick();
        bus.error_gnt_i = 1'b0;
        #1;
        chk("hold_req_drop", 96'(bus.error_req_o), 96'd0);

        // Saturated allocator gates legal AW only
        tick();
        bus.full_counter_i = 1'b1;
        set_aw(16'h0004, 6'h04, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("full_awvalid_o", 96'(bus.awvalid_o), 96'd0);
            chk("full_awready_o", 96'(bus.awready_o), 96'd0);
            chk("full_no_incr", 96'(bus.incr_req_o), 96'd0);
            tick();
        end
        bus.full_counter_i = 1'b0;
        #1;
        chk("unfull_awready", 96'(bus.awready_o), 96'd1);
        chk("unfull_incr", 96'(bus.incr_req_o), 96'd1);
        tick();
        bus.awvalid_i = 1'b0;
        bus.full_counter_i = 1'b1;
        fwd_beat(1'b1);
        set_aw(16'h0005, 6'h05, 8'd0, 1'b1);
        #1;
        chk("full_err_awready", 96'(bus.awready_o), 96'd1);
        chk("full_err_sample", 96'(bus.sample_awdata_info_o), 96'd1);
        tick();
        bus.awvalid_i = 1'b0;
        sink_beat(1'b1);
        bus.error_gnt_i = 1'b1;
        tick();
        bus.error_gnt_i = 1'b0;
        bus.full_counter_i = 1'b0;
        #1;
        chk("full_err_done", 96'(bus.error_req_o), 96'd0);
        chk("pre_mismatch", 96'(bus.wlast_mismatch_o), 96'd0);

        // awlen=1 but WLAST on beat 0
        set_aw(16'h0006, 6'h06, 8'd1, 1'b0);
        tick();
        bus.awvalid_i = 1'b0;
        fwd_beat(1'b1);
        #1;
        chk("early_last_flag", 96'(bus.wlast_mismatch_o), 96'd1);
        bus.wvalid_i = 1'b1;
        #1;
        chk("early_last_idle", 96'(bus.wready_o), 96'd0);
        bus.wvalid_i = 1'b0;
        repeat (3) tick();
        chk("early_last_sticky", 96'(bus.wlast_mismatch_o), 96'd1);

        // Reset during SINK_W beat 2
        set_aw(16'h0007, 6'h07, 8'd7, 1'b1);
        tick();
        bus.awvalid_i = 1'b0;
        sink_beat(1'b0);
        sink_beat(1'b0);
        drive_beat(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_wready", 96'(bus.wready_o), 96'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_wready2", 96'(bus.wready_o), 96'd0);
        chk("rst_mid_awready", 96'(bus.awready_o), 96'd0);
        chk("rst_mid_mismatch", 96'(bus.wlast_mismatch_o), 96'd0);
        bus.wvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_no_req", 96'(bus.error_req_o), 96'd0);
            tick();
        end
        chk("scoreboard_empty", 96'(exp_q.size()), 96'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
